// File: rtl/game_pkg.sv
// Shared definitions for the button event path: FSM state encoding and
// default timing thresholds for a 50 MHz system clock.
package game_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHORT = 2'd2,
    ST_LONG  = 2'd3
  } btn_state_t;

  localparam int DEFAULT_LONG_CYCLES   = 12_500_000;  // 250 ms
  localparam int DEFAULT_REPEAT_CYCLES = 5_000_000;   // 100 ms
  localparam int DEFAULT_W_CNT         = 24;

endpackage

// File: rtl/button_event_gen.sv
// Converts a debounced button level into registered single-cycle game events
// (press, release, tap, long press, auto-repeat) plus a held level.
module button_event_gen
  import game_pkg::*;
#(
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
  parameter int W_CNT         = DEFAULT_W_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic button_debounced_i,
  output logic press_o,
  output logic release_o,
  output logic tap_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic held_o
);

  localparam logic [W_CNT-1:0] LONG_LAST   = W_CNT'(LONG_CYCLES - 1);
  localparam logic [W_CNT-1:0] REPEAT_LAST = W_CNT'(REPEAT_CYCLES - 1);
  localparam logic [W_CNT-1:0] CNT_ONE     = W_CNT'(1);

  btn_state_t       state, state_next;
  logic [W_CNT-1:0] cnt, cnt_next;
  logic             press_next, release_next, tap_next;
  logic             long_next, repeat_next, held_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ARM;
      cnt          <= '0;
      press_o      <= 1'b0;
      release_o    <= 1'b0;
      tap_o        <= 1'b0;
      long_press_o <= 1'b0;
      repeat_o     <= 1'b0;
      held_o       <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      press_o      <= press_next;
      release_o    <= release_next;
      tap_o        <= tap_next;
      long_press_o <= long_next;
      repeat_o     <= repeat_next;
      held_o       <= held_next;
    end
  end

  // A low sample always wins over a threshold hit on the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_ARM: begin
        if (!button_debounced_i) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (button_debounced_i) begin
          state_next = ST_SHORT;
          cnt_next   = CNT_ONE;
        end
      end
      ST_SHORT: begin
        if (!button_debounced_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == LONG_LAST) begin
          state_next = ST_LONG;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (!button_debounced_i) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_ARM;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    press_next   = (state == ST_IDLE) && button_debounced_i;
    long_next    = (state == ST_SHORT) && button_debounced_i && (cnt == LONG_LAST);
    repeat_next  = (state == ST_LONG) && button_debounced_i && (cnt == REPEAT_LAST);
    release_next = ((state == ST_SHORT) || (state == ST_LONG)) && !button_debounced_i;
    tap_next     = (state == ST_SHORT) && !button_debounced_i;
    held_next    = (state_next == ST_SHORT) || (state_next == ST_LONG);
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with short thresholds (LONG=8, REPEAT=4).
module tb_button_event_gen;

  localparam int LC = 8;
  localparam int RC = 4;
  localparam int WC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;
  logic press_o, release_o, tap_o, long_press_o, repeat_o, held_o;
  logic [5:0] obs;
  logic [5:0] exp_v;
  int total = 0;
  int bad = 0;

  // obs bits: press, release, tap, long, repeat, held
  assign obs = {press_o, release_o, tap_o, long_press_o, repeat_o, held_o};

  button_event_gen #(
    .LONG_CYCLES  (LC),
    .REPEAT_CYCLES(RC),
    .W_CNT        (WC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .button_debounced_i(btn),
    .press_o           (press_o),
    .release_o         (release_o),
    .tap_o             (tap_o),
    .long_press_o      (long_press_o),
    .repeat_o          (repeat_o),
    .held_o            (held_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after the i-th consecutive high sample of an accepted press.
  function automatic logic [5:0] hold_expect(int i);
    logic [5:0] e;
    e = 6'b000001;
    if (i == 1) e[5] = 1'b1;
    if (i == LC) e[2] = 1'b1;
    if (i > LC && ((i - LC) % RC) == 0) e[1] = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    btn = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want %b", obs, 6'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (obs !== 6'b0) begin
        bad++;
        $display("FAIL held_through_reset cyc%0d: got %b want %b", i, obs, 6'b0);
      end
    end
    btn = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++;
      if (obs !== 6'b0) begin
        bad++;
        $display("FAIL arm_low cyc%0d: got %b want %b", i, obs, 6'b0);
      end
    end
    btn = 1'b1;
    tick();
    total++;
    if (obs !== 6'b100001) begin
      bad++;
      $display("FAIL first_press_after_arm: got %b want %b", obs, 6'b100001);
    end
    btn = 1'b0;
    tick();
    total++;
    if (obs !== 6'b011000) begin
      bad++;
      $display("FAIL glitch_release: got %b want %b", obs, 6'b011000);
    end
    tick();
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL idle_after_glitch: got %b want %b", obs, 6'b0);
    end
  endtask

  task automatic test_tap(input int n);
    for (int i = 1; i <= n; i++) begin
      btn = 1'b1;
      tick();
      exp_v = hold_expect(i);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL tap%0d_hold cyc%0d: got %b want %b", n, i, obs, exp_v);
      end
    end
    btn = 1'b0;
    tick();
    total++;
    if (obs !== 6'b011000) begin
      bad++;
      $display("FAIL tap%0d_release: got %b want %b", n, obs, 6'b011000);
    end
    tick();
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL tap%0d_idle: got %b want %b", n, obs, 6'b0);
    end
  endtask

  task automatic test_long(input int n);
    for (int i = 1; i <= n; i++) begin
      btn = 1'b1;
      tick();
      exp_v = hold_expect(i);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL long%0d_hold cyc%0d: got %b want %b", n, i, obs, exp_v);
      end
    end
    btn = 1'b0;
    tick();
    total++;
    if (obs !== 6'b010000) begin
      bad++;
      $display("FAIL long%0d_release: got %b want %b", n, obs, 6'b010000);
    end
    for (int i = 1; i <= RC + 1; i++) begin
      tick();
      total++;
      if (obs !== 6'b0) begin
        bad++;
        $display("FAIL long%0d_after_release cyc%0d: got %b want %b", n, i, obs, 6'b0);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    for (int i = 1; i <= 10; i++) begin
      btn = 1'b1;
      tick();
      exp_v = hold_expect(i);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL midrst_hold cyc%0d: got %b want %b", i, obs, exp_v);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL midrst_clear: got %b want %b", obs, 6'b0);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (obs !== 6'b0) begin
        bad++;
        $display("FAIL midrst_still_high cyc%0d: got %b want %b", i, obs, 6'b0);
      end
    end
    btn = 1'b0;
    tick();
    total++;
    if (obs !== 6'b0) begin
      bad++;
      $display("FAIL midrst_low_no_release: got %b want %b", obs, 6'b0);
    end
    btn = 1'b1;
    tick();
    total++;
    if (obs !== 6'b100001) begin
      bad++;
      $display("FAIL midrst_repress: got %b want %b", obs, 6'b100001);
    end
    btn = 1'b0;
    tick();
    total++;
    if (obs !== 6'b011000) begin
      bad++;
      $display("FAIL midrst_rerelease: got %b want %b", obs, 6'b011000);
    end
  endtask

  initial begin
    test_reset();
    test_tap(3);
    test_long(LC);
    test_tap(LC - 1);
    test_long(20);
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
